// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Write-side companion of the processor instruction memory. A byte stream
//   arriving over a valid/ready handshake is packed four bytes at a time,
//   big-endian (MIPS order), into 32-bit words. Each word is written to
//   consecutive word addresses of the instruction memory. The CPU is held off
//   for the whole load.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a modulo-256 sum of all image bytes is kept. After the last
//   word, one trailing checksum byte is accepted in a CHECK state. o_err is
//   set when the image sum plus the checksum byte is non-zero mod 256.
//   When undefined, the CHECK state and the sum logic are absent and o_err
//   is tied to 0.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (aborts any load in progress)
//   i_start      one-cycle load request, sampled only while idle
//   i_base_addr  first word address, latched on i_start
//   i_num_words  number of words to load, latched on i_start
//   i_byte       stream data byte
//   i_byte_valid stream byte valid
//   o_byte_ready loader accepts a byte this cycle
//   o_wr_en      memory write strobe, one cycle per word
//   o_wr_addr    memory write word address
//   o_wr_data    memory write data
//   o_busy       high in every state except IDLE
//   o_cpu_hold   copy of o_busy, drives the processor reset/stall
//   o_done       one-cycle pulse at the end of a load
//   o_err        checksum mismatch flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_num_words,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_cpu_hold,
    output logic                  o_done,
    output logic                  o_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_CHECK = 3'd4
    } state_t;
    // After the final word the trailing checksum byte must be consumed.
    localparam state_t S_AFTER_LAST = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
    } state_t;
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [CNT_WIDTH-1:0]    count_reg;
    logic [1:0]              byte_idx_reg;
    logic [DATA_WIDTH-1:0]   word_reg;
    logic                    ready;
    logic                    byte_accept;

    assign byte_accept = i_byte_valid && ready;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next = (i_num_words == '0) ? S_AFTER_LAST : S_RECV;
                end
            end
            S_RECV: begin
                if (byte_accept && (byte_idx_reg == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // count_reg still holds the pre-decrement value here.
                state_next = (count_reg == CNT_WIDTH'(1)) ? S_AFTER_LAST : S_RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (byte_accept) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready   = 1'b0;
        o_wr_en = 1'b0;
        o_done  = 1'b0;
        case (state_reg)
            S_RECV:  ready   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: ready   = 1'b1;
`endif
            S_WRITE: o_wr_en = 1'b1;
            S_DONE:  o_done  = 1'b1;
            default: ready   = 1'b0;
        endcase
    end

    assign o_byte_ready = ready;
    assign o_busy       = (state_reg != S_IDLE);
    assign o_cpu_hold   = o_busy;
    assign o_wr_addr    = addr_reg;
    assign o_wr_data    = word_reg;

    // Datapath: address/count tracking and byte packing. Shifting left by a
    // byte per accept leaves the first byte in [31:24] after four accepts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_reg     <= '0;
            count_reg    <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        addr_reg     <= i_base_addr;
                        count_reg    <= i_num_words;
                        byte_idx_reg <= '0;
                        word_reg     <= '0;
                    end
                end
                S_RECV: begin
                    if (byte_accept) begin
                        word_reg     <= {word_reg[DATA_WIDTH-9:0], i_byte};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                    end
                end
                S_WRITE: begin
                    // Natural ADDR_WIDTH overflow gives the wrap 1023 -> 0.
                    addr_reg  <= addr_reg + ADDR_WIDTH'(1);
                    count_reg <= count_reg - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;
    logic [7:0] check_total;
    logic       err_reg;

    assign check_total = sum_reg + i_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        sum_reg <= '0;
                        err_reg <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (byte_accept) begin
                        sum_reg <= check_total;
                    end
                end
                S_CHECK: begin
                    if (byte_accept) begin
                        err_reg <= (check_total != 8'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_err = err_reg;
`else
    assign o_err = 1'b0;
`endif

endmodule
